// File: rtl/pp_accumulator_pkg.sv
// Shared definitions for the partial-product accumulator: FSM states,
// default operand width and the truncation mask builder.
package pp_accumulator_pkg;

    typedef enum logic {
        ACC  = 1'b0,
        DONE = 1'b1
    } state_t;

    localparam int WIDTH_DEF = 16;

    // Mask with the low 'trunc' columns cleared; callers cast it to their product width.
    function automatic logic [63:0] trunc_mask(input int trunc);
        return ~((64'd1 << trunc) - 64'd1);
    endfunction

endpackage

// File: rtl/pp_shift_mask.sv
// Aligns one partial-product row to its column position and drops the
// truncated low columns, producing the addend for the accumulator.
module pp_shift_mask
    import pp_accumulator_pkg::*;
#(
    parameter int  WIDTH = WIDTH_DEF,
    parameter int  TRUNC = 0,
    localparam int CW    = (WIDTH > 1) ? $clog2(WIDTH) : 1,
    localparam int PW    = 2 * WIDTH
) (
    input  logic [WIDTH-1:0] row,
    input  logic [CW-1:0]    cnt,
    output logic [PW-1:0]    addend
);

    logic [PW-1:0] row_ext;
    logic [PW-1:0] mask;

    // Shift happens at full product width so no row bits are lost before masking.
    always_comb begin
        row_ext = {{WIDTH{1'b0}}, row};
        mask    = PW'(trunc_mask(TRUNC));
        addend  = (row_ext << cnt) & mask;
    end

endmodule

// File: rtl/pp_accumulator.sv
// Sequential partial-product accumulator: sums WIDTH shifted rows into a
// 2*WIDTH register and hands the finished product downstream.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   ACC   | accepting rows; pp_ready=1, acc grows by one row per handshake
//   DONE  | product complete; res_valid=1, res held until res_ready
module pp_accumulator
    import pp_accumulator_pkg::*;
#(
    parameter int  WIDTH = WIDTH_DEF,
    parameter int  TRUNC = 0,
    localparam int CW    = (WIDTH > 1) ? $clog2(WIDTH) : 1,
    localparam int PW    = 2 * WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             pp_valid,
    output logic             pp_ready,
    input  logic [WIDTH-1:0] pp_row,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [PW-1:0]    res
);

    localparam logic [CW-1:0] LAST_ROW = CW'(WIDTH - 1);

    state_t        state;
    state_t        state_nxt;
    logic [PW-1:0] acc;
    logic [PW-1:0] acc_nxt;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;
    logic [PW-1:0] addend;

    pp_shift_mask #(
        .WIDTH (WIDTH),
        .TRUNC (TRUNC)
    ) u_shift_mask (
        .row    (pp_row),
        .cnt    (cnt),
        .addend (addend)
    );

    // State, running sum and row index; reset drops any partial product.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ACC;
            acc   <= '0;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            acc   <= acc_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Handshake outputs and next-state; clear overrides any handshake this cycle.
    always_comb begin
        state_nxt = state;
        acc_nxt   = acc;
        cnt_nxt   = cnt;
        pp_ready  = 1'b0;
        res_valid = 1'b0;

        case (state)
            ACC: begin
                pp_ready = 1'b1;
                if (pp_valid) begin
                    acc_nxt = acc + addend;
                    if (cnt == LAST_ROW) begin
                        cnt_nxt   = '0;
                        state_nxt = DONE;
                    end else begin
                        cnt_nxt = cnt + CW'(1);
                    end
                end
            end
            DONE: begin
                res_valid = 1'b1;
                if (res_ready) begin
                    acc_nxt   = '0;
                    state_nxt = ACC;
                end
            end
            default: state_nxt = ACC;
        endcase

        if (clear) begin
            acc_nxt   = '0;
            cnt_nxt   = '0;
            state_nxt = ACC;
        end
    end

    assign res = acc;

endmodule

// File: tb/tb_pp_accumulator.sv
// Self-checking bench: an exact (TRUNC=0) and a truncating (TRUNC=4)
// accumulator see identical stimulus; each is compared against a product
// model built from the operands a and b with plain arithmetic.
module tb_pp_accumulator;

    localparam int W  = 16;
    localparam int T4 = 4;

    logic          clk;
    logic          rst_n;
    logic          clear;
    logic          pp_valid;
    logic [W-1:0]  pp_row;
    logic          res_ready;
    logic          pp_ready0, res_valid0;
    logic          pp_ready4, res_valid4;
    logic [2*W-1:0] res0, res4;

    int checks = 0;
    int errors = 0;

    // model state
    logic [63:0] exp0, exp4;
    logic [W-1:0] cur_a, cur_b;
    int m_cnt;

    pp_accumulator #(.WIDTH(W), .TRUNC(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .clear(clear), .pp_valid(pp_valid),
        .pp_ready(pp_ready0), .pp_row(pp_row), .res_valid(res_valid0),
        .res_ready(res_ready), .res(res0)
    );

    pp_accumulator #(.WIDTH(W), .TRUNC(T4)) dut4 (
        .clk(clk), .rst_n(rst_n), .clear(clear), .pp_valid(pp_valid),
        .pp_ready(pp_ready4), .pp_row(pp_row), .res_valid(res_valid4),
        .res_ready(res_ready), .res(res4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_start(input logic [W-1:0] a, input logic [W-1:0] b);
        cur_a = a;
        cur_b = b;
        m_cnt = 0;
        exp0  = 64'd0;
        exp4  = 64'd0;
    endtask

    // Feeds rows m_cnt..m_cnt+nrows-1 of a*b with up to max_gap idle cycles before each row.
    task automatic feed_rows(input int nrows, input int max_gap);
        logic [63:0] term;
        logic [W-1:0] row;
        int gaps;
        for (int i = 0; i < nrows; i++) begin
            row  = cur_b[m_cnt] ? cur_a : '0;
            gaps = (max_gap > 0) ? $urandom_range(0, max_gap) : 0;
            for (int g = 0; g < gaps; g++) begin
                pp_valid = 1'b0;
                pp_row   = W'($urandom);
                @(negedge clk);
                checks++;
                if (res0 !== exp0[31:0] || res4 !== exp4[31:0]) begin
                    errors++;
                    $display("FAIL gap_frozen row %0d: got %h/%h exp %h/%h", m_cnt, res0, res4, exp0[31:0], exp4[31:0]);
                end
            end
            pp_valid = 1'b1;
            pp_row   = row;
            checks++;
            if (pp_ready0 !== 1'b1 || pp_ready4 !== 1'b1) begin
                errors++;
                $display("FAIL row_ready row %0d: got %b/%b exp 1", m_cnt, pp_ready0, pp_ready4);
            end
            @(negedge clk);
            pp_valid = 1'b0;
            term = 64'(row) * (64'd1 << m_cnt);
            exp0 = exp0 + term;
            exp4 = exp4 + ((term >> T4) << T4);
            m_cnt++;
            checks++;
            if (res0 !== exp0[31:0] || res4 !== exp4[31:0]) begin
                errors++;
                $display("FAIL partial row %0d: got %h/%h exp %h/%h", m_cnt, res0, res4, exp0[31:0], exp4[31:0]);
            end
        end
    endtask

    task automatic check_done(input string tag);
        checks++;
        if (res_valid0 !== 1'b1 || res_valid4 !== 1'b1 || pp_ready0 !== 1'b0 || pp_ready4 !== 1'b0) begin
            errors++;
            $display("FAIL %s done_flags: valid %b/%b ready %b/%b exp valid 1 ready 0", tag, res_valid0, res_valid4, pp_ready0, pp_ready4);
        end
        checks++;
        if (res0 !== exp0[31:0] || res4 !== exp4[31:0]) begin
            errors++;
            $display("FAIL %s product: got %h/%h exp %h/%h", tag, res0, res4, exp0[31:0], exp4[31:0]);
        end
    endtask

    task automatic take_result(input string tag);
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        checks++;
        if (res_valid0 !== 1'b0 || res_valid4 !== 1'b0 || pp_ready0 !== 1'b1 || pp_ready4 !== 1'b1 || res0 !== 32'd0 || res4 !== 32'd0) begin
            errors++;
            $display("FAIL %s after_take: valid %b/%b ready %b/%b res %h/%h exp 0/0 1/1 0/0", tag, res_valid0, res_valid4, pp_ready0, pp_ready4, res0, res4);
        end
        model_start('0, '0);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (pp_ready0 !== 1'b1 || pp_ready4 !== 1'b1 || res_valid0 !== 1'b0 || res_valid4 !== 1'b0 || res0 !== 32'd0 || res4 !== 32'd0) begin
            errors++;
            $display("FAIL reset_state: ready %b/%b valid %b/%b res %h/%h", pp_ready0, pp_ready4, res_valid0, res_valid4, res0, res4);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_exact_max();
        model_start(16'hFFFF, 16'hFFFF);
        feed_rows(W, 0);
        check_done("max");
        checks++;
        if (res0 !== 32'hFFFE0001) begin
            errors++;
            $display("FAIL max_exact_const: got %h exp fffe0001", res0);
        end
        checks++;
        if (res4 !== 32'hFFFDFFD0) begin
            errors++;
            $display("FAIL max_trunc_const: got %h exp fffdffd0", res4);
        end
        take_result("max");
    endtask

    task automatic test_sparse();
        model_start(16'd3, 16'd5);
        feed_rows(W, 3);
        check_done("sparse");
        checks++;
        if (res0 !== 32'd15) begin
            errors++;
            $display("FAIL sparse_const: got %h exp 0000000f", res0);
        end
        take_result("sparse");
    endtask

    task automatic test_random();
        for (int n = 0; n < 6; n++) begin
            model_start(W'($urandom), W'($urandom));
            feed_rows(W, (n % 2 == 0) ? 0 : 2);
            check_done("random");
            checks++;
            if (res0 !== 32'(cur_a) * 32'(cur_b)) begin
                errors++;
                $display("FAIL random_product: got %h exp %h", res0, 32'(cur_a) * 32'(cur_b));
            end
            take_result("random");
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] held0, held4;
        model_start(W'($urandom), W'($urandom));
        feed_rows(W, 0);
        check_done("bp");
        held0 = res0;
        held4 = res4;
        res_ready = 1'b0;
        pp_valid  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            pp_row = W'($urandom);
            @(negedge clk);
            checks++;
            if (res_valid0 !== 1'b1 || res_valid4 !== 1'b1 || pp_ready0 !== 1'b0 || pp_ready4 !== 1'b0 || res0 !== held0 || res4 !== held4) begin
                errors++;
                $display("FAIL bp_hold cycle %0d: valid %b/%b ready %b/%b res %h/%h exp 1/1 0/0 %h/%h", i, res_valid0, res_valid4, pp_ready0, pp_ready4, res0, res4, held0, held4);
            end
        end
        pp_valid = 1'b0;
        take_result("bp");
        // The next product must start from zero; partial checks inside feed_rows catch any stray row.
        model_start(W'($urandom), W'($urandom));
        feed_rows(W, 1);
        check_done("bp_next");
        take_result("bp_next");
    endtask

    task automatic test_reset_mid();
        model_start(W'($urandom) | 16'h0101, 16'hFFFF);
        feed_rows(7, 0);
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if (pp_ready0 !== 1'b1 || pp_ready4 !== 1'b1 || res_valid0 !== 1'b0 || res_valid4 !== 1'b0 || res0 !== 32'd0 || res4 !== 32'd0) begin
            errors++;
            $display("FAIL reset_mid: ready %b/%b valid %b/%b res %h/%h exp 1/1 0/0 0/0", pp_ready0, pp_ready4, res_valid0, res_valid4, res0, res4);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        model_start(W'($urandom), W'($urandom));
        feed_rows(W, 1);
        check_done("after_reset");
        take_result("after_reset");
    endtask

    task automatic test_clear();
        model_start(W'($urandom) | 16'h8001, 16'hFFFF);
        feed_rows(9, 0);
        clear    = 1'b1;
        pp_valid = 1'b1;
        pp_row   = 16'hFFFF;
        @(negedge clk);
        clear    = 1'b0;
        pp_valid = 1'b0;
        checks++;
        if (res0 !== 32'd0 || res4 !== 32'd0 || pp_ready0 !== 1'b1 || res_valid0 !== 1'b0) begin
            errors++;
            $display("FAIL clear_acc: res %h/%h ready %b valid %b exp 0/0 1 0", res0, res4, pp_ready0, res_valid0);
        end
        model_start(W'($urandom), W'($urandom));
        feed_rows(W, 0);
        check_done("after_clear");
        // clear in DONE wins over a simultaneous result handshake
        clear     = 1'b1;
        res_ready = 1'b1;
        @(negedge clk);
        clear     = 1'b0;
        res_ready = 1'b0;
        checks++;
        if (res0 !== 32'd0 || res_valid0 !== 1'b0 || pp_ready0 !== 1'b1 || res_valid4 !== 1'b0) begin
            errors++;
            $display("FAIL clear_done: res %h valid %b/%b ready %b exp 0 0/0 1", res0, res_valid0, res_valid4, pp_ready0);
        end
        model_start(W'($urandom), W'($urandom));
        feed_rows(W, 2);
        check_done("after_clear_done");
        take_result("after_clear_done");
    endtask

    initial begin
        rst_n     = 1'b0;
        clear     = 1'b0;
        pp_valid  = 1'b0;
        pp_row    = '0;
        res_ready = 1'b0;
        model_start('0, '0);
        @(negedge clk);
        test_reset();
        test_exact_max();
        test_sparse();
        test_random();
        test_backpressure();
        test_reset_mid();
        test_clear();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pp_accumulator.md
# pp_accumulator

Sequential partial-product accumulator: the consuming end of the partial product generator. It accepts one 16-bit partial-product row per cycle over a valid/ready handshake and shifts each row by its row index. It adds the shifted rows into a 2×WIDTH register and presents the finished product over a second valid/ready handshake. It sits between the PPG row source and the error-recovery/output stage of the approximate multiplier, and an optional truncation mode approximates the product.

## Interface
- WIDTH, 16, operand width; rows per product = WIDTH; product width = 2*WIDTH
- TRUNC, 0, number of low product columns forced to zero in every added row (0 = exact); legal range 0..WIDTH
- clk  in  1  sole clock, rising edge
- rst_n  in  1  reset, asynchronous assert, active-low
- clear  in  1  synchronous abort: discard the partial sum and return to row 0
- pp_valid  in  1  pp_row is valid
- pp_ready  out  1  block accepts a row this cycle
- pp_row  in  WIDTH  partial-product row (a & {WIDTH{b[k]}}); row index k is implicit, 0 first
- res_valid  out  1  res holds a completed product
- res_ready  in  1  downstream accepts res
- res  out  2*WIDTH  accumulated product

## Operation
- FSM states: ACC and DONE. Reset state is ACC.
- ACC: pp_ready=1, res_valid=0. When pp_valid&&pp_ready, acc <= acc + ((pp_row << cnt) & ~((1<<TRUNC)-1)) and cnt <= cnt+1.
- ACC→DONE when the row with cnt==WIDTH-1 is accepted; cnt wraps to 0.
- DONE: pp_ready=0, res_valid=1, res=acc, held stable until res_ready. On res_valid&&res_ready: acc <= 0, then →ACC.
- Arithmetic is unsigned. The 2*WIDTH accumulator cannot overflow: the maximum is (2^WIDTH−1)^2. The shift operates at 2*WIDTH bits before masking.
- clear, in any state, sets acc <= 0, cnt <= 0 and →ACC next cycle. Any row or result handshake in the same cycle is ignored. clear has priority over everything except rst_n.
- pp_valid while pp_ready=0 has no effect. The source holds its row; no rows are dropped or double-counted.
- rst_n low at any time, including mid-product: acc=0, cnt=0, state=ACC immediately (asynchronous). The partial product is lost.
- res is driven directly from acc, with no separate output register.

## Timing
- Reset values: pp_ready=1, res_valid=0, res=0.
- res_valid rises the cycle after the WIDTH-th row handshake.
- Minimum period per product is WIDTH+1 cycles: WIDTH row cycles plus one DONE cycle with res_ready=1.
- In the res handshake cycle pp_ready=0, so a new row cannot overlap. The first row of the next product is accepted at the earliest one cycle after the res handshake.
- Back-pressure on res holds res_valid and res unchanged indefinitely.
- Stalls on pp_valid insert idle cycles without changing acc or cnt.

## Structure
- The shared multiplier package holds:
  - the state enum {ACC, DONE}
  - the WIDTH default
  - a function that builds the truncation mask from TRUNC
- Optional sub-module pp_shift_mask is combinational: row, cnt → shifted and masked 2*WIDTH addend. Everything else lives in one module.
- cnt width is $clog2(WIDTH).

## Test plan
- Exact multiply with WIDTH=16, TRUNC=0, a=0xFFFF, b=0xFFFF: 16 rows of 0xFFFF back-to-back → res_valid after row 16, res=0xFFFE0001.
- Sparse rows for a=3, b=5: rows 3,0,3,0,… (13 zeros follow) with random pp_valid gaps → res=15, acc/cnt frozen during gaps.
- Truncation with TRUNC=4: 16 rows of 0xFFFF → res=0xFFFDFFD0 (low nibble 0).
- Back-pressure: hold res_ready=0 for 5 cycles in DONE → res_valid stays 1, res stable, pp_ready=0, offered rows not consumed. Then res_ready=1 → next product starts from acc=0.
- Reset mid-operation: deassert rst_n after 7 rows → pp_ready=1, res_valid=0, res=0 immediately. A fresh 16-row product then yields the correct result.
- clear after 9 rows, asserted together with pp_valid → that row is ignored, acc=0, cnt=0. The next 16 rows give the exact product of those rows only.
